// File: rtl/pe_v5_vec_mac_pkg.sv
// pe_pkg: beat mode encoding and the result fit (saturate or wrap) helper.
package pe_pkg;
  typedef enum logic {PE_PASS = 1'b0, PE_ACC = 1'b1} pe_mode_e;
  localparam int FIT_W = 128;
  function automatic logic signed [FIT_W-1:0] fit(input logic signed [FIT_W-1:0] x, input int unsigned w, input bit sat);
    logic signed [FIT_W-1:0] hi, lo;
    hi = (FIT_W'(1) <<< (w - 1)) - FIT_W'(1);
    lo = ~hi;
    return !sat ? x : x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/pe_v5_vec_mac_lane.sv
// pe_v5_lane: one lane; stage-1 registered product, stage-2 add into pass result or accumulator.
module pe_v5_lane import pe_pkg::*; #(
  parameter int REG_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter bit SAT       = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [REG_WIDTH-1:0] a_i,
  input  logic signed [REG_WIDTH-1:0] b_i,
  input  logic signed [REG_WIDTH-1:0] c_i,
  input  logic                        s2_i,
  input  pe_mode_e                    mode_i,
  input  logic                        last_i,
  input  logic                        clr_i,
  output logic        [REG_WIDTH-1:0] c_o
);
  localparam int PW = 2 * REG_WIDTH;
  (* use_dsp = "yes" *) logic signed [PW-1:0] p_q;
  logic signed [REG_WIDTH-1:0] c_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [PW:0] pass_d;
  logic [REG_WIDTH-1:0] res_d;
  always_comb begin
    acc_d  = (clr_i ? '0 : acc_q) + ACC_WIDTH'(p_q);
    pass_d = (PW + 1)'(c_q) + (PW + 1)'(p_q);
    res_d  = REG_WIDTH'(fit(mode_i == PE_ACC ? FIT_W'(acc_d) : FIT_W'(pass_d), REG_WIDTH, SAT));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      c_q   <= '0;
      acc_q <= '0;
      c_o   <= '0;
    end else begin
      p_q <= a_i * b_i;
      c_q <= c_i;
      if (s2_i && mode_i == PE_ACC) acc_q <= acc_d;
      if (s2_i && (mode_i == PE_PASS || last_i)) c_o <= res_d;
    end
  end
endmodule

// File: rtl/pe_v5_vec_mac.sv
// pe_v5_vec_mac: vector multiply-accumulate PE with systolic forwarding of a/b and beat control.
module pe_v5_vec_mac import pe_pkg::*; #(
  parameter int REG_WIDTH = 16,
  parameter int VECTOR    = 4,
  parameter int ACC_WIDTH = 40,
  parameter bit B_BCAST   = 1,
  parameter bit SAT       = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic                               mode,
  input  logic                               last,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]   a_in,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]   b_in,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]   c_in,
  output logic                               out_valid,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]   a_out,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]   b_out,
  output logic                               mode_out,
  output logic                               last_out,
  output logic                               c_valid,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]   c_out
);
  if (ACC_WIDTH < 2 * REG_WIDTH) begin : g_bad_acc
    $error("ACC_WIDTH must be at least 2*REG_WIDTH");
  end
  logic [VECTOR-1:0][REG_WIDTH-1:0] b_sel;
  logic v1_q, last1_q, clr_q, cv_q;
  pe_mode_e mode1_q;
  for (genvar g = 0; g < VECTOR; g++) begin : g_lane
    assign b_sel[g] = B_BCAST ? b_in[0] : b_in[g];
    pe_v5_lane #(.REG_WIDTH(REG_WIDTH), .ACC_WIDTH(ACC_WIDTH), .SAT(SAT)) u_lane (
      .clk(clk), .rst(rst), .a_i(a_in[g]), .b_i(b_sel[g]), .c_i(c_in[g]),
      .s2_i(v1_q), .mode_i(mode1_q), .last_i(last1_q), .clr_i(clr_q), .c_o(c_out[g])
    );
  end
  assign c_valid = cv_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      mode_out  <= 1'b0;
      last_out  <= 1'b0;
      v1_q      <= 1'b0;
      mode1_q   <= PE_PASS;
      last1_q   <= 1'b0;
      clr_q     <= 1'b1;
      cv_q      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      a_out     <= a_in;
      b_out     <= b_sel;
      mode_out  <= mode;
      last_out  <= last;
      v1_q      <= in_valid;
      mode1_q   <= pe_mode_e'(mode);
      last1_q   <= last;
      cv_q      <= v1_q && (mode1_q == PE_PASS || last1_q);
      // the last beat of a dot product arms a fresh start for the next ACC beat
      if (v1_q && mode1_q == PE_ACC) clr_q <= last1_q;
    end
  end
endmodule

// File: tb/tb_pe_v5_vec_mac.sv
// tb_pe_v5_vec_mac: checks a saturating broadcast PE and a wrapping per-lane PE against an arithmetic model.
module tb_pe_v5_vec_mac;
  localparam int W = 16, V = 4;
  logic clk = 1'b0, rst, in_valid, mode, last;
  logic [V-1:0][W-1:0] a_in, b_in, c_in;
  logic out_valid[2], mode_out[2], last_out[2], c_valid[2];
  logic [V-1:0][W-1:0] a_out[2], b_out[2], c_out[2];
  int checks = 0, errors = 0;
  int ta[V], tbv[V], tc[V];
  longint acc[2][V], pval[2][V], ecout[2][V], eb[2][V], ea[V];
  bit clr[2] = '{1'b1, 1'b1}, pv[2], ecv[2], eov, emode, elast;
  always #5 clk = ~clk;
  pe_v5_vec_mac u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .last(last),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .out_valid(out_valid[0]), .a_out(a_out[0]),
    .b_out(b_out[0]), .mode_out(mode_out[0]), .last_out(last_out[0]), .c_valid(c_valid[0]), .c_out(c_out[0])
  );
  pe_v5_vec_mac #(.ACC_WIDTH(32), .B_BCAST(0), .SAT(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .last(last),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .out_valid(out_valid[1]), .a_out(a_out[1]),
    .b_out(b_out[1]), .mode_out(mode_out[1]), .last_out(last_out[1]), .c_valid(c_valid[1]), .c_out(c_out[1])
  );
  task automatic chk(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint sx(longint v, int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction
  function automatic longint fitm(longint v, bit s);
    if (s) return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    return sx(v, W);
  endfunction
  task automatic set(int a0, int a1, int a2, int a3, int b, int c);
    ta = '{a0, a1, a2, a3};
    for (int i = 0; i < V; i++) begin
      tbv[i] = b;
      tc[i]  = c;
    end
  endtask
  task automatic cyc(bit r, bit v, bit m, bit l);
    longint p;
    @(negedge clk);
    rst = r; in_valid = v; mode = m; last = l;
    for (int i = 0; i < V; i++) begin
      a_in[i] = ta[i][W-1:0];
      b_in[i] = tbv[i][W-1:0];
      c_in[i] = tc[i][W-1:0];
    end
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        ecv[k] = 0; pv[k] = 0; clr[k] = 1;
        for (int i = 0; i < V; i++) begin
          acc[k][i] = 0; ecout[k][i] = 0; eb[k][i] = 0;
        end
      end else begin
        ecv[k] = pv[k];
        if (pv[k]) for (int i = 0; i < V; i++) ecout[k][i] = pval[k][i];
        pv[k] = v && (!m || l);
        for (int i = 0; i < V; i++) begin
          eb[k][i] = sx(k == 0 ? tbv[0] : tbv[i], W);
          p = sx(ta[i], W) * eb[k][i];
          if (v && !m) pval[k][i] = fitm(sx(tc[i], W) + p, k == 0);
          if (v && m) begin
            acc[k][i] = sx((clr[k] ? 0 : acc[k][i]) + p, k == 0 ? 40 : 32);
            pval[k][i] = fitm(acc[k][i], k == 0);
          end
        end
        if (v && m) clr[k] = l;
      end
    end
    eov = r ? 0 : v;
    emode = r ? 0 : m;
    elast = r ? 0 : l;
    for (int i = 0; i < V; i++) ea[i] = r ? 0 : sx(ta[i], W);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("out_valid%0d", k), out_valid[k], eov);
      chk($sformatf("mode_out%0d", k), mode_out[k], emode);
      chk($sformatf("last_out%0d", k), last_out[k], elast);
      chk($sformatf("c_valid%0d", k), c_valid[k], ecv[k]);
      for (int i = 0; i < V; i++) begin
        chk($sformatf("a_out%0d[%0d]", k, i), $signed(a_out[k][i]), ea[i]);
        chk($sformatf("b_out%0d[%0d]", k, i), $signed(b_out[k][i]), eb[k][i]);
        chk($sformatf("c_out%0d[%0d]", k, i), $signed(c_out[k][i]), ecout[k][i]);
      end
    end
  endtask
  task automatic lane_is(string tag, int k, longint exp);
    for (int i = 0; i < V; i++) chk($sformatf("%s[%0d]", tag, i), $signed(c_out[k][i]), exp);
  endtask
  initial begin
    rst = 1; in_valid = 0; mode = 0; last = 0; a_in = '0; b_in = '0; c_in = '0;
    set(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 1);
    chk("rst_c_valid", c_valid[0], 0);
    set(2, 3, -4, 5, 7, 1);
    tbv[1] = 99;
    cyc(0, 1, 0, 0);
    for (int i = 0; i < V; i++) chk($sformatf("bcast_b[%0d]", i), $signed(b_out[0][i]), 7);
    cyc(0, 0, 0, 0);
    chk("pass_l0", $signed(c_out[0][0]), 15);
    chk("pass_l1", $signed(c_out[0][1]), 22);
    chk("pass_l2", $signed(c_out[0][2]), -27);
    chk("pass_l3", $signed(c_out[0][3]), 36);
    chk("pass_cv", c_valid[0], 1);
    set(1, 1, 1, 1, 10, 0); cyc(0, 1, 1, 0);
    set(2, 2, 2, 2, 10, 0); cyc(0, 1, 1, 0);
    set(3, 3, 3, 3, 10, 0); cyc(0, 1, 1, 1);
    set(4, 4, 4, 4, 10, 0); cyc(0, 1, 1, 1);
    lane_is("acc60", 0, 60);
    cyc(0, 0, 0, 0);
    lane_is("acc40", 0, 40);
    set(300, 300, 300, 300, 300, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    lane_is("sat", 0, 32767);
    lane_is("wrap", 1, 24464);
    set(5, 5, 5, 5, 5, 0); cyc(0, 1, 1, 0);
    set(2, 2, 2, 2, 2, 1); cyc(0, 1, 0, 0);
    set(1, 1, 1, 1, 1, 0); cyc(0, 1, 1, 1);
    lane_is("ilv_pass", 0, 5);
    cyc(0, 0, 0, 0);
    lane_is("ilv_acc", 0, 26);
    set(7, 7, 7, 7, 7, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
    cyc(1, 0, 0, 0);
    set(3, 3, 3, 3, 3, 0); cyc(0, 1, 1, 1); cyc(0, 0, 0, 0);
    lane_is("rst_acc", 0, 9);
    set(1, 1, 1, 1, 10, 0); cyc(0, 1, 1, 0);
    for (int j = 0; j < 3; j++) cyc(0, 0, 1, 1);
    set(2, 2, 2, 2, 10, 0); cyc(0, 1, 1, 0);
    for (int j = 0; j < 3; j++) cyc(0, 0, 0, 1);
    set(3, 3, 3, 3, 10, 0); cyc(0, 1, 1, 1); cyc(0, 0, 0, 0);
    lane_is("bubble", 0, 60);
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < V; i++) begin
        ta[i]  = (n % 3 == 0) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 40)) - 20;
        tbv[i] = int'($urandom_range(0, 65535)) - 32768;
        tc[i]  = int'($urandom_range(0, 65535)) - 32768;
      end
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_v5_vec_mac.md
PE_V5_VEC_MAC -- requirements
Module: pe_v5_vec_mac

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 16, width of each lane operand and result (signed two's complement).
REQ-002 SHALL have parameter VECTOR, default 4, number of lanes.
REQ-003 SHALL have parameter ACC_WIDTH, default 40, internal accumulator width; legal only if ACC_WIDTH >= 2*REG_WIDTH.
REQ-004 SHALL have parameter B_BCAST, default 1; when set, 1 broadcasts b_in[0] to all lanes; when 0, lanes use their own b_in[i].
REQ-005 SHALL have parameter SAT, default 1; when set, 1 saturates results to REG_WIDTH; when 0, wraps (truncates).
REQ-006 clk  input  1  single clock, all logic on posedge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  beat present on a_in/b_in/c_in.
REQ-009 mode  input  1  per-beat mode: 0 = PASS (systolic a*b+c), 1 = ACC (output-stationary accumulate).
REQ-010 last  input  1  ACC mode only: final beat of the current dot product.
REQ-011 a_in, b_in, c_in  input  VECTOR x REG_WIDTH  lane operands from the upstream PE.
REQ-012 out_valid  output  1  a_out/b_out/mode_out/last_out are valid.
REQ-013 a_out, b_out  output  VECTOR x REG_WIDTH  registered forward to the downstream PE.
REQ-014 mode_out, last_out  output  1 each  registered forward of mode/last.
REQ-015 c_valid  output  1  c_out holds a result.
REQ-016 c_out  output  VECTOR x REG_WIDTH  lane results.

Function
REQ-017 a_out, b_out, mode_out, last_out and out_valid SHALL equal the inputs delayed exactly 1 cycle; b_out[i] SHALL be b_in[0] for all i when B_BCAST=1.
REQ-018 The block SHALL have no backpressure; every in_valid beat SHALL be accepted.
REQ-019 Pipeline: stage 1 SHALL register the full-width signed product p[i]=a_in[i]*b_sel[i] (2*REG_WIDTH bits), c_in[i], mode and last; stage 2 SHALL perform the add.
REQ-020 PASS beat at cycle t: c_out[i] = fit(sext(c_in[i]) + p[i]) and c_valid=1 at t+2; the accumulator is not modified.
REQ-021 ACC beat at cycle t: acc[i] <= (acc_clear ? 0 : acc[i]) + sext(p[i]) at stage 2; c_valid is not asserted unless last=1.
REQ-022 ACC beat with last=1 at t: c_out[i] = fit(updated acc[i]) with c_valid=1 at t+2; acc_clear SHALL set so the next ACC beat (even at t+1) starts from 0.
REQ-023 fit(): SAT=1 clamps to [-2^(REG_WIDTH-1), 2^(REG_WIDTH-1)-1]; SAT=0 takes the low REG_WIDTH bits.
REQ-024 The accumulator SHALL wrap at ACC_WIDTH without flagging.
REQ-025 When c_valid=0, c_out SHALL hold its previous value.
REQ-026 Beats with in_valid=0 SHALL be bubbles: no accumulator change and no c_valid.
REQ-027 Interleaved PASS beats during an open ACC sequence SHALL leave acc[i] intact.
REQ-028 Back-to-back beats of any mode mix SHALL be sustained at 1 beat/cycle.

Reset
REQ-029 While rst=1 at a clock edge, all valids, acc[i] and all data outputs SHALL become 0 and acc_clear SHALL become 1; in-flight beats are discarded.
REQ-030 A beat presented on the same edge as rst=1 SHALL be dropped; the first beat after rst deasserts SHALL be processed normally.

Structure
REQ-031 Package pe_pkg SHALL hold the mode enum (PE_PASS, PE_ACC) and the fit/saturate function.
REQ-032 Per-lane multiply/add/accumulate SHALL be a sub-module pe_v5_lane, instantiated VECTOR times by generate; handshake/forward registers stay in the top.
REQ-033 Stage-1 product and stage-2 add SHALL be structured to map to one DSP slice per lane (use_dsp).

Verification (REG_WIDTH=16, VECTOR=4)
REQ-034 PASS: a=(2,3,-4,5), b[0]=7, c=(1,1,1,1), B_BCAST=1 -> at t+2, c_out=(15,22,-27,36), c_valid=1; a_out/b_out at t+1 with b_out=(7,7,7,7).
REQ-035 ACC: beats a=1,2,3 all lanes, b=10, last on third -> one c_valid, c_out=60 all lanes; next single ACC beat 4*10 with last -> 40.
REQ-036 SAT: PASS a=300, b=300, c=0 -> c_out=32767; SAT=0 -> 90000 mod 2^16 = 24464.
REQ-037 Interleave: ACC 5*5, PASS 2*2+1, ACC 1*1 last -> PASS result 5, then ACC result 26.
REQ-038 Reset mid-ACC: two ACC beats, rst for 1 cycle, then ACC 3*3 last -> c_out=9; no c_valid during or after rst until that result.
REQ-039 Bubbles: ACC beats separated by 3 idle cycles produce the same sum as back-to-back beats.
